gpio_event_ctrl: RTL and testbench

GPIO_EVENT_CTRL -- requirements
Module: gpio_event_ctrl

---
 rtl/gpio_event_ctrl.sv | 106 ++++++++++
 tb/tb_gpio_event_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_event_ctrl.sv
// GPIO event controller: per-bit input filter, sticky edge events with masked irq, and set/clr/toggle outputs.
// Define GPIO_EVT_DEBOUNCE_EN to build the per-bit debounce counters; otherwise in_level simply follows sync_in.
module gpio_event_ctrl #(
  parameter int INPUT_IO  = 8,
  parameter int OUTPUT_IO = 8,
  parameter int DB_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INPUT_IO-1:0]  sync_in,
  input  logic [INPUT_IO-1:0]  rise_en,
  input  logic [INPUT_IO-1:0]  fall_en,
  input  logic [INPUT_IO-1:0]  irq_mask,
  input  logic [INPUT_IO-1:0]  evt_clear,
  input  logic [DB_W-1:0]      db_limit,
  input  logic [OUTPUT_IO-1:0] out_set,
  input  logic [OUTPUT_IO-1:0] out_clr,
  input  logic [OUTPUT_IO-1:0] out_tgl,
  output logic [OUTPUT_IO-1:0] out_io,
  output logic [INPUT_IO-1:0]  in_level,
  output logic [INPUT_IO-1:0]  evt_status,
  output logic                 irq
);

  logic [INPUT_IO-1:0]  in_level_q, in_level_d;
  logic [INPUT_IO-1:0]  evt_pend_q, evt_pend_d;
  logic [INPUT_IO-1:0]  evt_status_q, evt_status_d;
  logic                 irq_q, irq_d;
  logic [OUTPUT_IO-1:0] out_io_q, out_io_d;

`ifdef GPIO_EVT_DEBOUNCE_EN
  logic [DB_W-1:0] cnt_q [INPUT_IO];
  logic [DB_W-1:0] cnt_d [INPUT_IO];

  // The counter saturates at db_limit: reaching it commits the new level instead of wrapping.
  always_comb begin
    in_level_d = in_level_q;
    for (int i = 0; i < INPUT_IO; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_in[i] == in_level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < db_limit) begin
        cnt_d[i] = cnt_q[i] + DB_W'(1);
      end else begin
        in_level_d[i] = sync_in[i];
        cnt_d[i]      = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < INPUT_IO; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < INPUT_IO; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  logic unused_db_limit;
  assign unused_db_limit = ^db_limit;

  always_comb begin
    in_level_d = sync_in;
  end
`endif

  // Edges are qualified with the enables present while the level is committed,
  // then posted to the status register one edge later.
  always_comb begin
    evt_pend_d   = (in_level_d & ~in_level_q & rise_en) |
                   (~in_level_d & in_level_q & fall_en);
    evt_status_d = (evt_status_q & ~evt_clear) | evt_pend_q;
    irq_d        = |(evt_status_q & irq_mask);
  end

  always_comb begin
    out_io_d = out_io_q;
    for (int i = 0; i < OUTPUT_IO; i++) begin
      if (out_clr[i])      out_io_d[i] = 1'b0;
      else if (out_set[i]) out_io_d[i] = 1'b1;
      else if (out_tgl[i]) out_io_d[i] = ~out_io_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_level_q   <= '0;
      evt_pend_q   <= '0;
      evt_status_q <= '0;
      irq_q        <= 1'b0;
      out_io_q     <= '0;
    end else begin
      in_level_q   <= in_level_d;
      evt_pend_q   <= evt_pend_d;
      evt_status_q <= evt_status_d;
      irq_q        <= irq_d;
      out_io_q     <= out_io_d;
    end
  end

  assign in_level   = in_level_q;
  assign evt_status = evt_status_q;
  assign irq        = irq_q;
  assign out_io     = out_io_q;

endmodule

// File: tb/tb_gpio_event_ctrl.sv
// Bench for gpio_event_ctrl: directed scenarios plus random traffic, all checked against a behavioural model.
module tb_gpio_event_ctrl;
  localparam int NI = 8;
  localparam int NO = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [NI-1:0] sync_in, rise_en, fall_en, irq_mask, evt_clear;
  logic [DW-1:0] db_limit;
  logic [NO-1:0] out_set, out_clr, out_tgl;
  logic [NO-1:0] out_io;
  logic [NI-1:0] in_level, evt_status;
  logic          irq;

  always #5 clk = ~clk;

  gpio_event_ctrl #(.INPUT_IO(NI), .OUTPUT_IO(NO), .DB_W(DW)) dut (
    .clk(clk), .reset(reset), .sync_in(sync_in), .rise_en(rise_en), .fall_en(fall_en),
    .irq_mask(irq_mask), .evt_clear(evt_clear), .db_limit(db_limit),
    .out_set(out_set), .out_clr(out_clr), .out_tgl(out_tgl),
    .out_io(out_io), .in_level(in_level), .evt_status(evt_status), .irq(irq)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: committed level, run length of disagreement, events awaiting posting.
  logic [NI-1:0] m_level, m_pend, m_status;
  logic [NO-1:0] m_out;
  logic          m_irq;
  int            m_run [NI];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = '0; m_pend = '0; m_status = '0; m_out = '0; m_irq = 1'b0;
    for (int i = 0; i < NI; i++) m_run[i] = 0;
  endtask

  // A level is accepted once the input has disagreed for more than db_limit consecutive samples.
  task automatic model_edge();
    logic [NI-1:0] nl;
    nl = m_level;
    for (int i = 0; i < NI; i++) begin
`ifdef GPIO_EVT_DEBOUNCE_EN
      if (sync_in[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] > int'(db_limit)) begin
          nl[i] = sync_in[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
`else
      nl[i] = sync_in[i];
`endif
    end
    m_irq    = |(m_status & irq_mask);
    m_status = (m_status & ~evt_clear) | m_pend;
    m_pend   = (nl & ~m_level & rise_en) | (~nl & m_level & fall_en);
    m_level  = nl;
    m_out    = ((m_out ^ out_tgl) | out_set) & ~out_clr;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".out_io"},     32'(out_io),     32'(m_out));
    check_eq({tag, ".in_level"},   32'(in_level),   32'(m_level));
    check_eq({tag, ".evt_status"}, 32'(evt_status), 32'(m_status));
    check_eq({tag, ".irq"},        32'(irq),        32'(m_irq));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic clear_pulses();
    evt_clear = '0; out_set = '0; out_clr = '0; out_tgl = '0;
  endtask

  task automatic wait_lvl(input int idx, input logic val);
    int k;
    k = 0;
    while (in_level[idx] !== val && k < 40) begin
      cycle("wait");
      k++;
    end
    check_eq("wait_lvl", 32'(in_level[idx]), 32'(val));
  endtask

  // Raise reset between edges and confirm the outputs clear before any clock edge.
  task automatic async_reset(input string tag);
    #3;
    reset = 1'b1;
    #1;
    check_eq({tag, ".rst_out"},   32'(out_io),     32'd0);
    check_eq({tag, ".rst_lvl"},   32'(in_level),   32'd0);
    check_eq({tag, ".rst_stat"},  32'(evt_status), 32'd0);
    check_eq({tag, ".rst_irq"},   32'(irq),        32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_all({tag, ".rst_hold"});
    @(negedge clk);
    reset = 1'b0;
  endtask

  int lat;

  initial begin
    reset = 1'b1;
    sync_in = '0; rise_en = '0; fall_en = '0; irq_mask = '0; db_limit = 16'd3;
    clear_pulses();
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

`ifdef GPIO_EVT_DEBOUNCE_EN
    lat = 4;
`else
    lat = 1;
`endif

    // Held rising input: level, then status, then irq on successive edges.
    rise_en = 8'h01; irq_mask = 8'h01; sync_in[0] = 1'b1;
    for (int i = 0; i < lat - 1; i++) cycle("r030");
    check_eq("r030.lvl_early", 32'(in_level[0]), 32'd0);
    cycle("r030");
    check_eq("r030.lvl", 32'(in_level[0]), 32'd1);
    cycle("r030");
    check_eq("r030.stat", 32'(evt_status[0]), 32'd1);
    check_eq("r030.irq_early", 32'(irq), 32'd0);
    cycle("r030");
    check_eq("r030.irq", 32'(irq), 32'd1);

    // Short glitch on bit 2.
    rise_en = 8'h05; sync_in[2] = 1'b1;
    cycle("r031"); cycle("r031");
    sync_in[2] = 1'b0;
    for (int i = 0; i < 5; i++) cycle("r031");
`ifdef GPIO_EVT_DEBOUNCE_EN
    check_eq("r031.lvl", 32'(in_level[2]), 32'd0);
    check_eq("r031.stat", 32'(evt_status[2]), 32'd0);
`endif

    // Clear colliding with a new falling event keeps the flag set.
    irq_mask = 8'h02; rise_en = 8'h02; fall_en = 8'h02; sync_in[1] = 1'b1;
    wait_lvl(1, 1'b1);
    cycle("r032");
    evt_clear = 8'hFD;
    cycle("r032");
    clear_pulses();
    sync_in[1] = 1'b0;
    wait_lvl(1, 1'b0);
    evt_clear = 8'h02;
    cycle("r032");
    check_eq("r032.keep", 32'(evt_status[1]), 32'd1);
    cycle("r032");
    clear_pulses();
    check_eq("r032.clr", 32'(evt_status[1]), 32'd0);
    check_eq("r032.irq_lag", 32'(irq), 32'd1);
    cycle("r032");
    check_eq("r032.irq_drop", 32'(irq), 32'd0);

    // Output pulse priority.
    out_set = 8'h0F; out_clr = 8'h03;
    cycle("r033");
    check_eq("r033.setclr", 32'(out_io), 32'h0C);
    clear_pulses(); out_tgl = 8'hFF;
    cycle("r033");
    check_eq("r033.tgl", 32'(out_io), 32'hF3);
    clear_pulses();
    cycle("r033.hold");

    // Reset mid-count, then a high input after release is a fresh rising event.
    out_clr = 8'hFF;
    cycle("r034");
    clear_pulses(); out_set = 8'hA5;
    cycle("r034");
    clear_pulses();
    check_eq("r034.out", 32'(out_io), 32'hA5);
    sync_in[0] = 1'b0; rise_en = 8'h01; irq_mask = 8'h01;
    cycle("r034");
    async_reset("r034");
    sync_in = 8'h01;
    wait_lvl(0, 1'b1);
    cycle("r034");
    check_eq("r034.stat", 32'(evt_status[0]), 32'd1);

`ifndef GPIO_EVT_DEBOUNCE_EN
    db_limit = 16'd100;
    for (int i = 0; i < 6; i++) begin
      logic [NI-1:0] prev;
      prev = 8'(($urandom));
      sync_in = prev;
      cycle("r035");
      check_eq("r035.follow", 32'(in_level), 32'(prev));
    end
`endif

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      if (c % 200 == 0) db_limit = 16'($urandom_range(0, 6));
      if (c % 50 == 0) begin
        rise_en = 8'($urandom); fall_en = 8'($urandom); irq_mask = 8'($urandom);
      end
      sync_in   = sync_in ^ 8'($urandom & $urandom & $urandom);
      evt_clear = 8'($urandom & $urandom & $urandom);
      out_set   = 8'($urandom & $urandom);
      out_clr   = 8'($urandom & $urandom);
      out_tgl   = 8'($urandom & $urandom);
      if (c == 777) async_reset("rnd");
      else cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
